// File: rtl/rr_log_arbiter_if.sv
// Logging-bus bundle between the recorder sources, the packet arbiter and the log writer.
// The arbiter connects through the slave modport; the environment uses master.
interface rr_log_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 512
);
   localparam int SRC_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          out_valid;
   logic [DATA_WIDTH-1:0]         out_data;
   logic [SRC_W-1:0]              out_src;
   logic                          out_last;
   logic                          out_ready;
   logic                          credit_ret;
   logic                          logb_almful;
   logic                          err_credit_ovf;

   modport master (
      output req_valid, req_data, req_last, out_ready, credit_ret,
      input  req_ready, out_valid, out_data, out_src, out_last, logb_almful, err_credit_ovf
   );

   modport slave (
      input  req_valid, req_data, req_last, out_ready, credit_ret,
      output req_ready, out_valid, out_data, out_src, out_last, logb_almful, err_credit_ovf
   );
endinterface

// File: rtl/rr_log_arbiter.sv
// Packet-granular round-robin arbiter merging recorder beat streams onto one logging bus,
// with a single output register stage and downstream credit tracking.
module rr_log_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 512,
   parameter int CREDITS       = 64,
   parameter int ALMFUL_THRESH = 8
) (
   input  logic               clk,
   input  logic               rstn,
   rr_log_arbiter_if.slave    bus
);
   localparam int SRC_W  = $clog2(NUM_REQ);
   localparam int CRED_W = $clog2(CREDITS + 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                state_q, state_d;
   logic [SRC_W-1:0]      grant_q, grant_d;
   logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [SRC_W-1:0]      out_src_q, out_src_d;
   logic                  out_last_q, out_last_d;
   logic [CRED_W-1:0]     credits_q, credits_d;
   logic                  almful_q, almful_d;
   logic                  err_ovf_q, err_ovf_d;

   logic [SRC_W-1:0]      cand_idx [NUM_REQ];
   logic [DATA_WIDTH-1:0] req_beat [NUM_REQ];
   logic                  scan_hit;
   logic [SRC_W-1:0]      scan_idx;
   logic                  can_load;
   logic                  load;
   logic [NUM_REQ-1:0]    req_ready;

   // cand_idx[k] is the requester k places after rr_ptr, wrapped modulo NUM_REQ
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [SRC_W:0] sum;
      assign sum          = {1'b0, rr_ptr_q} + (SRC_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (SRC_W+1)'(NUM_REQ)) ? SRC_W'(sum - (SRC_W+1)'(NUM_REQ))
                                                          : SRC_W'(sum);
      assign req_beat[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // Walk from the far end so the candidate closest to rr_ptr wins
   always_comb begin
      scan_hit = 1'b0;
      scan_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req_valid[cand_idx[k]]) begin
            scan_hit = 1'b1;
            scan_idx = cand_idx[k];
         end
      end
   end

   assign can_load = (!out_valid_q || bus.out_ready) && (credits_q != '0);
   assign load     = (state_q == LOCKED) && can_load && bus.req_valid[grant_q];

   always_comb begin
      req_ready = '0;
      if (state_q == LOCKED) req_ready[grant_q] = can_load;
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_last_d  = out_last_q;
      credits_d   = credits_q;
      err_ovf_d   = err_ovf_q;

      case (state_q)
         IDLE: begin
            if (scan_hit) begin
               state_d = LOCKED;
               grant_d = scan_idx;
            end
         end
         LOCKED: begin
            if (load && bus.req_last[grant_q]) begin
               state_d  = IDLE;
               rr_ptr_d = (grant_q == SRC_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = req_beat[grant_q];
         out_src_d   = grant_q;
         out_last_d  = bus.req_last[grant_q];
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      // A load paired with a returned slot is a net no-op on the credit count
      if (load && !bus.credit_ret) begin
         credits_d = credits_q - 1'b1;
      end else if (bus.credit_ret && !load) begin
         if (credits_q == CRED_W'(CREDITS)) err_ovf_d = 1'b1;
         else                               credits_d = credits_q + 1'b1;
      end

      almful_d = (credits_d <= CRED_W'(ALMFUL_THRESH));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_last_q  <= 1'b0;
         credits_q   <= CRED_W'(CREDITS);
         almful_q    <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_last_q  <= out_last_d;
         credits_q   <= credits_d;
         almful_q    <= almful_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   assign bus.req_ready      = req_ready;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_data       = out_data_q;
   assign bus.out_src        = out_src_q;
   assign bus.out_last       = out_last_q;
   assign bus.logb_almful    = almful_q;
   assign bus.err_credit_ovf = err_ovf_q;
endmodule

// File: tb/tb_rr_log_arbiter.sv
// Scoreboard bench for rr_log_arbiter: expected beats are queued as packets are offered
// and popped as the logging bus hands them downstream.
module tb_rr_log_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int CRED = 64;
   localparam int THR  = 8;
   localparam int MEMD = 80;

   typedef struct packed {
      logic [1:0]    src;
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic clk;
   logic rstn;

   rr_log_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW)) bus ();

   rr_log_arbiter #(
      .NUM_REQ(NREQ), .DATA_WIDTH(DW), .CREDITS(CRED), .ALMFUL_THRESH(THR)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   logic [DW-1:0] mem_data [NREQ][MEMD];
   bit            mem_last [NREQ][MEMD];
   int            head [NREQ];
   int            tail [NREQ];
   int            fire_cnt [NREQ];
   exp_t          exp_q [$];

   bit oready        = 1'b1;
   int ret_mode      = 0;   // 0 none, 1 one per delivered beat, 2 refill to full, 3 once alongside a load
   bit manual_ret    = 1'b0;
   bit prev_out_fire = 1'b0;
   bit mchk          = 1'b0;
   bit gap_chk       = 1'b0;
   int last_fire     = -1;
   int cyc           = 0;
   int cred_m        = CRED;
   bit err_m         = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   task automatic enq(input int r, input int nb, input int pid);
      exp_t e;
      for (int b = 0; b < nb; b++) begin
         mem_data[r][tail[r]] = {8'(r), 8'(pid), 16'(b)};
         mem_last[r][tail[r]] = (b == nb - 1);
         e.src  = 2'(r);
         e.data = mem_data[r][tail[r]];
         e.last = mem_last[r][tail[r]];
         exp_q.push_back(e);
         tail[r]++;
      end
   endtask

   task automatic clear_fires();
      for (int i = 0; i < NREQ; i++) fire_cnt[i] = 0;
   endtask

   // One clock cycle: drive at the falling edge, sample just after, commit at the next rise
   task automatic tick();
      logic [NREQ-1:0] fire;
      bit   ret;
      bit   out_fire;
      exp_t e;
      @(negedge clk);
      if (rstn && mchk) begin
         chk("almful", 64'(bus.logb_almful), 64'(cred_m <= THR));
         chk("err_ovf", 64'(bus.err_credit_ovf), 64'(err_m));
      end
      for (int i = 0; i < NREQ; i++) begin
         if (head[i] < tail[i]) begin
            bus.req_valid[i]          = 1'b1;
            bus.req_data[i*DW +: DW]  = mem_data[i][head[i]];
            bus.req_last[i]           = mem_last[i][head[i]];
         end else begin
            bus.req_valid[i]          = 1'b0;
            bus.req_data[i*DW +: DW]  = '0;
            bus.req_last[i]           = 1'b0;
         end
      end
      bus.out_ready = oready;
      ret = manual_ret || (ret_mode == 1 && prev_out_fire) || (ret_mode == 2 && cred_m < CRED);
      manual_ret = 1'b0;
      #1;
      fire = bus.req_valid & bus.req_ready;
      for (int i = 0; i < NREQ; i++) begin
         if (fire[i]) begin
            head[i]++;
            fire_cnt[i]++;
         end
      end
      if (ret_mode == 3 && fire != '0) begin
         ret      = 1'b1;
         ret_mode = 0;
      end
      bus.credit_ret = ret;
      out_fire = bus.out_valid && bus.out_ready;
      if (out_fire) begin
         $display("beat src=%0d data=%08h last=%0b", bus.out_src, bus.out_data, bus.out_last);
         if (exp_q.size() == 0) begin
            chk("sb_extra", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            chk("out_src", 64'(bus.out_src), 64'(e.src));
            chk("out_data", 64'(bus.out_data), 64'(e.data));
            chk("out_last", 64'(bus.out_last), 64'(e.last));
         end
      end
      prev_out_fire = out_fire;
      if (gap_chk && fire != '0) begin
         if (last_fire >= 0) chk("pkt_gap", 64'(cyc - last_fire), 64'd2);
         last_fire = cyc;
      end
      if (fire != '0 && !ret) cred_m--;
      else if (ret && fire == '0) begin
         if (cred_m == CRED) err_m = 1'b1;
         else                cred_m++;
      end
      cyc++;
   endtask

   function automatic bit all_done();
      bit d = (exp_q.size() == 0) && !bus.out_valid && (ret_mode == 0 || cred_m == CRED);
      for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) d = 1'b0;
      return d;
   endfunction

   task automatic drain(input string tag);
      bit done = 1'b0;
      for (int n = 0; n < 400 && !done; n++) begin
         tick();
         done = all_done();
      end
      chk(tag, 64'(done), 64'd1);
   endtask

   task automatic run_fires(input string tag, input int r, input int cnt);
      for (int n = 0; n < 300 && fire_cnt[r] < cnt; n++) tick();
      chk(tag, 64'(fire_cnt[r]), 64'(cnt));
   endtask

   logic [DW-1:0] held;

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         head[i] = 0;
         tail[i] = 0;
         fire_cnt[i] = 0;
      end
      bus.req_valid  = '0;
      bus.req_data   = '0;
      bus.req_last   = '0;
      bus.out_ready  = 1'b1;
      bus.credit_ret = 1'b0;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_almful", 64'(bus.logb_almful), 64'd0);
      chk("rst_err", 64'(bus.err_credit_ovf), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      rstn = 1'b1;
      mchk = 1'b1;

      // Fairness: every requester keeps one-beat packets pending
      ret_mode = 1;
      for (int p = 0; p < 3; p++)
         for (int r = 0; r < NREQ; r++) enq(r, 1, p);
      gap_chk = 1'b1;
      drain("fair_drain");
      gap_chk = 1'b0;

      // Packet lock: req1 waits behind req0's three-beat packet
      enq(0, 3, 10);
      enq(1, 1, 11);
      for (int n = 0; n < 50 && !all_done(); n++) begin
         tick();
         if (head[0] < tail[0]) chk("lock_rdy1", 64'(bus.req_ready[1]), 64'd0);
      end
      drain("lock_drain");

      // Backpressure for five cycles mid-packet
      clear_fires();
      enq(2, 6, 20);
      run_fires("bp_pre", 2, 2);
      oready = 1'b0;
      tick();
      held = bus.out_data;
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      for (int n = 0; n < 5; n++) begin
         chk("bp_ready", 64'(bus.req_ready[2]), 64'd0);
         chk("bp_hold", 64'(bus.out_data), 64'(held));
         if (n < 4) tick();
      end
      oready = 1'b1;
      drain("bp_drain");

      // Credit return while already full
      manual_ret = 1'b1;
      tick();
      tick();
      chk("ovf_set", 64'(bus.err_credit_ovf), 64'd1);

      // Exhaustion: no returns, 65-beat packet stalls after 64 beats
      ret_mode = 0;
      clear_fires();
      enq(3, 65, 30);
      run_fires("exh_64", 3, 64);
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("exh_ready", 64'(bus.req_ready[3]), 64'd0);
      end
      chk("exh_almful", 64'(bus.logb_almful), 64'd1);
      chk("exh_stall", 64'(fire_cnt[3]), 64'd64);
      manual_ret = 1'b1;
      repeat (4) tick();
      chk("exh_one", 64'(fire_cnt[3]), 64'd65);

      // Return eight slots, then pair a return with the first load at credits 8
      repeat (8) begin
         manual_ret = 1'b1;
         tick();
      end
      clear_fires();
      enq(1, 12, 40);
      ret_mode = 3;
      repeat (20) tick();
      chk("simul_cnt", 64'(fire_cnt[1]), 64'd9);
      chk("simul_rdy", 64'(bus.req_ready[1]), 64'd0);
      ret_mode = 2;
      drain("simul_drain");
      chk("err_sticky", 64'(bus.err_credit_ovf), 64'd1);

      // Asynchronous reset during beat 2 of a 4-beat packet
      ret_mode = 1;
      clear_fires();
      enq(2, 4, 50);
      run_fires("rst_pre", 2, 2);
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_out_data", 64'(bus.out_data), 64'd0);
      chk("arst_out_src", 64'(bus.out_src), 64'd0);
      chk("arst_out_last", 64'(bus.out_last), 64'd0);
      chk("arst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("arst_almful", 64'(bus.logb_almful), 64'd0);
      chk("arst_err", 64'(bus.err_credit_ovf), 64'd0);
      for (int i = 0; i < NREQ; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      exp_q.delete();
      cred_m = CRED;
      err_m = 1'b0;
      prev_out_fire = 1'b0;
      tick();
      rstn = 1'b1;
      enq(1, 1, 60);
      enq(3, 1, 61);
      drain("post_rst_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rr_log_arbiter.md
# rr_log_arbiter

Round-robin arbiter that shares one logging-bus write stream among NUM_REQ recorder sources (e.g. multiple axi_recorder instances). It grants whole packets, where a packet is a run of beats ending in `req_last`. Granted beats go through one output register stage. A credit counter tracks free downstream buffer slots, and the block drives `logb_almful` back to all recorders. It sits between the per-interface recorders and the log storage/DMA writer.

## Interface
- NUM_REQ, default 4: number of requesters, range 2..16.
- DATA_WIDTH, default 512: beat width in bits.
- CREDITS, default 64: downstream buffer depth in beats.
- ALMFUL_THRESH, default 8: `logb_almful` asserts when credits ≤ this value; must be < CREDITS.
- Derived: SRC_W = $clog2(NUM_REQ); CRED_W = $clog2(CREDITS+1).

Ports (reset is asynchronous and active-low):
- clk  in  1  sole clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  final beat of the packet.
- req_ready  out  NUM_REQ  beat accepted when req_valid[i] && req_ready[i].
- out_valid  out  1  registered beat valid.
- out_data  out  DATA_WIDTH  registered beat.
- out_src  out  SRC_W  index of the requester that produced the beat.
- out_last  out  1  registered copy of req_last.
- out_ready  in  1  downstream accept.
- credit_ret  in  1  single-cycle pulse; one downstream slot freed.
- logb_almful  out  1  registered; credits ≤ ALMFUL_THRESH.
- err_credit_ovf  out  1  sticky; credit_ret arrived while credits == CREDITS.

## Operation
- The FSM has two states, IDLE and LOCKED, and resets to IDLE.
- In IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first set bit becomes `grant`, and the state goes to LOCKED next cycle.
  - If no request is valid, stay in IDLE.
  - req_ready is all zero in IDLE.
- In LOCKED:
  - req_ready[grant] = can_load. All other req_ready bits are 0.
  - can_load = (!out_valid || out_ready) && (credits != 0).
- Accepting a beat:
  - Load out_data, out_src = grant, and out_last, and set out_valid.
  - Decrement credits.
- Accepting a beat with req_last = 1:
  - Return to IDLE.
  - rr_ptr = (grant == NUM_REQ-1) ? 0 : grant+1.
- Output register:
  - If out_valid && out_ready and no new load occurs, clear out_valid.
  - out_data/out_src/out_last stay stable while out_valid && !out_ready.
- Credits:
  - Reset to CREDITS.
  - Load and credit_ret in the same cycle: credits unchanged.
  - credit_ret alone: credits increment, saturating at CREDITS.
  - credit_ret while credits == CREDITS: err_credit_ovf sets and stays set until reset.
- A granted requester that drops req_valid mid-packet keeps the lock. There is no timeout; the packet must complete.
- A requester deasserting req_valid while in IDLE before being granted is legal. The scan in that cycle decides the grant.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, out_last=0, req_ready=0, logb_almful=0 (credits=CREDITS), err_credit_ovf=0, rr_ptr=0, state=IDLE.
- Arbitration overhead is 1 cycle per packet: the IDLE decision cycle, then LOCKED from the next edge.
- Input-to-output latency is 1 cycle: a beat accepted at edge N is on out_* after edge N.
- Sustained throughput is 1 beat/cycle within a packet when out_ready=1 and credits > 0.
- The minimum packet gap is 1 cycle (the IDLE cycle), including back-to-back packets from the same requester.
- logb_almful is registered from next-state credits, so it changes the same edge credits change.
- req_ready is combinational from state, out_valid, out_ready, and credits. It has no combinational path from req_valid.
- Asynchronous reset mid-packet: every register returns to its reset value immediately, and the in-flight out beat is discarded.

## Test plan
- Fairness: NUM_REQ=4, all requesters send 1-beat packets continuously, out_ready=1, credit_ret on every accept. Grants run 0,1,2,3,0…, out_src matches, and each packet takes 2 cycles.
- Packet lock: req0 sends a 3-beat packet and req1 is valid throughout. The out_src sequence is 0,0,0 then 1, and req_ready[1] stays 0 until req0's last beat is accepted.
- Backpressure: out_ready=0 for 5 cycles mid-packet. out_data holds its value, req_ready[grant]=0, and no beat is lost or duplicated after release.
- Credit exhaustion: CREDITS=64, no credit_ret. logb_almful rises after the 56th accept, req_ready drops after the 64th, and one credit_ret pulse allows exactly one more beat.
- Simultaneous load and credit_ret with credits=8: credits stay 8 and logb_almful stays 1. A credit_ret at credits=64 sets err_credit_ovf and credits stay 64.
- Reset: assert rstn=0 during beat 2 of a 4-beat packet. All outputs reach their reset values without waiting for a clock. After release, the first grant goes to the lowest-index valid requester.
